mmio_timer_intc: RTL and testbench
==================================

Name: mmio_timer_intc

Overview:
- Memory-mapped timer and interrupt front-end on the CPU data-memory bus, in parallel with data RAM.
- Consumes the MEM-stage bus signals: address, store data, write enable and read strobe.
- Drives the CPU's 5-bit external interrupt vector. Bit 4 is the counter interrupt, which becomes IP7 in CAUSE.
- Supplies read data for the top-level MEM-stage read mux via a select flag.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00: base of the 256-byte register window. Hit when mem_addr[31:8]==BASE_ADDR[31:8].
- EXT_N, 4: number of external interrupt lines, fixed at 4 to fill int_[3:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_addr  input  32  MEM-stage byte address.
- mem_data  input  32  MEM-stage store data.
- mem_we  input  1  store strobe, one cycle per store.
- mem_rd  input  1  load strobe.
- ext_irq  input  4  asynchronous external interrupt pins, level-high.
- sel  output  1  address in window; the top-level mux takes rd_data instead of RAM.
- rd_data  output  32  register read data.
- int_  output  5  to CPU int_ input: [4] timer, [3:0] external.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Register map (word offsets; mem_addr[1:0] ignored; unmapped offsets read 0 and ignore writes):
  - 0x00 COUNT, RW, 32 bits.
  - 0x04 COMPARE, RW, 32 bits.
  - 0x08 CTRL, RW: [0] EN, [1] AUTORELOAD, [2] TIE, [7:4] EMASK; other bits read 0.
  - 0x0C STATUS, write-1-to-clear: [0] TPEND, [4:1] EPEND.
  - 0x10 PRESCALE, RW, 16 bits, zero-extended on read.
- Reads:
  - sel and rd_data are combinational from mem_addr and current register state, valid in the same cycle.
  - rd_data=0 when sel=0.
  - Reads have no side effects; mem_rd is informational only.
- Writes: take effect at the clk edge ending the cycle with mem_we=1 and sel=1.
- Tick:
  - 16-bit prescaler counter PCNT runs while EN=1.
  - When PCNT==PRESCALE, tick=1 for that cycle and PCNT<=0; otherwise PCNT<=PCNT+1.
  - PRESCALE=0 gives a tick every cycle. EN=0 holds PCNT at 0.
- Count, on each tick:
  - If COUNT==COMPARE: TPEND<=1; COUNT<=AUTORELOAD ? 0 : COUNT+1.
  - Else COUNT<=COUNT+1, wrapping 0xFFFF_FFFF to 0 silently with no pending.
- Simultaneous events:
  - A software write to COUNT overrides that cycle's tick update, and no match is evaluated that cycle.
  - A write to COMPARE clears TPEND.
  - A hardware set of TPEND or EPEND in the same cycle as a W1C clear of that bit: set wins.
- External lines:
  - Per bit: two-flop synchroniser s1, s2, then delay flop s3. Rising edge = s2&~s3, which sets EPEND[i].
  - Pins are edge-triggered: a level held high produces exactly one pending.
  - A 0→1 change at a pin before edge k gives EPEND=1 after edge k+2.
- Interrupt outputs:
  - int_[4] = TPEND & TIE.
  - int_[3:0] = EPEND & EMASK.
  - Combinational from flops only, so glitch-free. Masking does not clear pending.
- Reset (at the clk edge with rst=1, mid-operation included):
  - COUNT, COMPARE, CTRL, STATUS, PRESCALE, PCNT, s1–s3 <= 0.
  - Hence int_=0 and rd_data reads 0.
  - Edges present on pins during reset are discarded.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined: PRESCALE register and PCNT exist as described.
- Undefined: no PRESCALE/PCNT storage; offset 0x10 reads 0 and ignores writes; tick = EN every cycle.

Test Plan:
- Reset, then read 0x00–0x10 → all read 0. sel=1 for mem_addr=0xFFFF_FF04; sel=0 and rd_data=0 for 0x0000_1000.
- Free-run with AUTORELOAD:
  - Write COMPARE=5, PRESCALE=0, CTRL=0x07.
  - → TPEND and int_[4] rise on the 6th tick after the CTRL write (count values 0..5). COUNT reads 0 on the next cycle, and rises again 6 ticks later.
  - Write STATUS=1 → int_[4] drops the next cycle.
- Prescale (macro defined):
  - Write PRESCALE=3, COMPARE=2, CTRL=0x05.
  - → COUNT advances every 4 cycles; int_[4]=1 after 12 cycles. COMPARE rewrite → TPEND=0.
- Wrap:
  - Write COUNT=0xFFFF_FFFE, COMPARE=0x10, CTRL=0x05, PRESCALE=0.
  - → reads 0xFFFF_FFFF, then 0x0000_0000; no TPEND at the wrap.
- External edge:
  - CTRL[7:4]=4'b0010. Raise ext_irq[1] and hold.
  - → EPEND[1] set 2 edges later and int_[1]=1. W1C STATUS=0x04 → clears, and it stays clear while the pin stays high.
  - ext_irq[0] edge with mask 0 → STATUS[1]=1 but int_[0]=0.
- Collision:
  - W1C of TPEND in the same cycle as a COUNT==COMPARE tick → TPEND remains 1.
  - Assert rst mid-count → all registers 0 and int_=0 after that edge.

Source files
------------

// File: rtl/mmio_timer_intc.sv
// Memory-mapped timer plus edge-triggered external interrupt front-end on the data-memory bus.
// Build option: define TIMER_PRESCALE_EN to add the PRESCALE register and prescaler counter.
module mmio_timer_intc #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          EXT_N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_data,
    input  logic             mem_we,
    input  logic             mem_rd,
    input  logic [EXT_N-1:0] ext_irq,
    output logic             sel,
    output logic [31:0]      rd_data,
    output logic [4:0]       int_
);

    typedef enum logic [5:0] {
        REG_COUNT    = 6'h00,
        REG_COMPARE  = 6'h01,
        REG_CTRL     = 6'h02,
        REG_STATUS   = 6'h03,
        REG_PRESCALE = 6'h04
    } reg_word_e;

    logic [5:0] word;
    logic       wr;
    logic       wr_count, wr_compare, wr_ctrl, wr_status, wr_prescale;

    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             en_q, en_d;
    logic             autoreload_q, autoreload_d;
    logic             tie_q, tie_d;
    logic [EXT_N-1:0] emask_q, emask_d;
    logic             tpend_q, tpend_d;
    logic [EXT_N-1:0] epend_q, epend_d;
    logic [EXT_N-1:0] s1_q, s2_q, s3_q;

    logic             tick;
    logic             match;
    logic [EXT_N-1:0] ext_rise;
    logic [EXT_N-1:0] ext_clr;
    logic [31:0]      prescale_rd;

    // Loads are side-effect free and the byte lanes are irrelevant to word registers.
    logic unused_bus;
    assign unused_bus = ^{mem_rd, mem_addr[1:0]};

    assign sel  = (mem_addr[31:8] == BASE_ADDR[31:8]);
    assign word = mem_addr[7:2];
    assign wr   = mem_we & sel;

    assign wr_count    = wr && (word == REG_COUNT);
    assign wr_compare  = wr && (word == REG_COMPARE);
    assign wr_ctrl     = wr && (word == REG_CTRL);
    assign wr_status   = wr && (word == REG_STATUS);
    assign wr_prescale = wr && (word == REG_PRESCALE);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q, pcnt_d;

    always_comb begin
        prescale_d = wr_prescale ? mem_data[15:0] : prescale_q;
        tick       = en_q && (pcnt_q == prescale_q);
        pcnt_d     = (!en_q || tick) ? 16'd0 : pcnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign prescale_rd = {16'd0, prescale_q};
`else
    logic unused_prescale;
    assign unused_prescale = wr_prescale;
    assign tick            = en_q;
    assign prescale_rd     = '0;
`endif

    // A software COUNT write owns the cycle: no increment and no match evaluation.
    assign match = tick && !wr_count && (count_q == compare_q);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        count_d      = count_q;
        compare_d    = compare_q;
        en_d         = en_q;
        autoreload_d = autoreload_q;
        tie_d        = tie_q;
        emask_d      = emask_q;

        if (wr_count) begin
            count_d = mem_data;
        end else if (tick) begin
            count_d = (match && autoreload_q) ? 32'd0 : count_q + 32'd1;
        end

        if (wr_compare) begin
            compare_d = mem_data;
        end

        if (wr_ctrl) begin
            en_d         = mem_data[0];
            autoreload_d = mem_data[1];
            tie_d        = mem_data[2];
            emask_d      = mem_data[7:4];
        end
    end

    // Hardware sets take priority over any software clear landing in the same cycle.
    assign ext_rise = s2_q & ~s3_q;
    assign ext_clr  = wr_status ? mem_data[4:1] : '0;

    always_comb begin
        tpend_d = match | (tpend_q & ~(wr_status & mem_data[0]) & ~wr_compare);
        epend_d = ext_rise | (epend_q & ~ext_clr);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            count_q      <= '0;
            compare_q    <= '0;
            en_q         <= 1'b0;
            autoreload_q <= 1'b0;
            tie_q        <= 1'b0;
            emask_q      <= '0;
            tpend_q      <= 1'b0;
            epend_q      <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
        end else begin
            count_q      <= count_d;
            compare_q    <= compare_d;
            en_q         <= en_d;
            autoreload_q <= autoreload_d;
            tie_q        <= tie_d;
            emask_q      <= emask_d;
            tpend_q      <= tpend_d;
            epend_q      <= epend_d;
            s1_q         <= ext_irq;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (word)
                REG_COUNT:    rd_data = count_q;
                REG_COMPARE:  rd_data = compare_q;
                REG_CTRL:     rd_data = {24'd0, emask_q, 1'b0, tie_q, autoreload_q, en_q};
                REG_STATUS:   rd_data = {27'd0, epend_q, tpend_q};
                REG_PRESCALE: rd_data = prescale_rd;
                default:      rd_data = '0;
            endcase
        end
    end

    // Driven only from flops, so the CPU sees glitch-free request lines.
    assign int_ = {tpend_q & tie_q, epend_q & emask_q};

endmodule

// File: tb/tb_mmio_timer_intc.sv
// Directed self-checking bench for mmio_timer_intc; expected values are hand-computed per step.
module tb_mmio_timer_intc;

    localparam logic [31:0] A_COUNT    = 32'hFFFF_FF00;
    localparam logic [31:0] A_COMPARE  = 32'hFFFF_FF04;
    localparam logic [31:0] A_CTRL     = 32'hFFFF_FF08;
    localparam logic [31:0] A_STATUS   = 32'hFFFF_FF0C;
    localparam logic [31:0] A_PRESCALE = 32'hFFFF_FF10;
    localparam logic [31:0] A_UNMAPPED = 32'hFFFF_FF20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        mem_rd;
    logic [3:0]  ext_irq;
    logic        sel;
    logic [31:0] rd_data;
    logic [4:0]  int_;

    int errors = 0;
    int checks = 0;

    mmio_timer_intc dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .ext_irq  (ext_irq),
        .sel      (sel),
        .rd_data  (rd_data),
        .int_     (int_)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Store commits at the next rising edge; returns 1ns after that edge.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_addr = a;
        mem_data = d;
        mem_we   = 1'b1;
        @(posedge clk);
        #1;
        mem_we   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_addr = a;
        mem_rd   = 1'b1;
        #1;
        check(tag, rd_data, exp);
        mem_rd   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst      = 1'b1;
        mem_addr = '0;
        mem_data = '0;
        mem_we   = 1'b0;
        mem_rd   = 1'b0;
        ext_irq  = '0;
        step(2);
        check("rst_int", {27'd0, int_}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and decode
        rd_chk("rst_count",    A_COUNT,    32'd0);
        rd_chk("rst_compare",  A_COMPARE,  32'd0);
        rd_chk("rst_ctrl",     A_CTRL,     32'd0);
        rd_chk("rst_status",   A_STATUS,   32'd0);
        rd_chk("rst_prescale", A_PRESCALE, 32'd0);
        mem_addr = 32'hFFFF_FF04;
        #1 check("sel_hit", {31'd0, sel}, 32'd1);
        mem_addr = 32'h0000_1000;
        #1 check("sel_miss", {31'd0, sel}, 32'd0);
        check("rd_miss", rd_data, 32'd0);
        bus_wr(A_UNMAPPED, 32'hDEAD_BEEF);
        rd_chk("unmapped", A_UNMAPPED, 32'd0);
        bus_wr(A_CTRL, 32'hFFFF_FFFF);
        rd_chk("ctrl_bits", A_CTRL, 32'h0000_00F7);
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_COUNT, 32'd0);
        bus_wr(A_PRESCALE, 32'h0001_0007);
`ifdef TIMER_PRESCALE_EN
        rd_chk("prescale_rw", A_PRESCALE, 32'h0000_0007);
`else
        rd_chk("prescale_rw", A_PRESCALE, 32'h0000_0000);
`endif

        // Free-run with autoreload: match on the 6th tick after enabling
        bus_wr(A_COMPARE, 32'd5);
        bus_wr(A_PRESCALE, 32'd0);
        bus_wr(A_CTRL, 32'h07);
        step(5);
        rd_chk("fr_count5", A_COUNT, 32'd5);
        check("fr_int_lo", {27'd0, int_}, 32'd0);
        step(1);
        check("fr_int_hi", {27'd0, int_}, 32'h10);
        rd_chk("fr_reload", A_COUNT, 32'd0);
        step(5);
        rd_chk("fr_count5b", A_COUNT, 32'd5);
        step(1);
        rd_chk("fr_reload2", A_COUNT, 32'd0);
        rd_chk("fr_status", A_STATUS, 32'd1);
        bus_wr(A_STATUS, 32'd1);
        check("fr_w1c_int", {27'd0, int_}, 32'd0);
        rd_chk("fr_w1c_status", A_STATUS, 32'd0);

`ifdef TIMER_PRESCALE_EN
        // Prescale 3: COUNT advances every 4 cycles, match 2 lands after 12 cycles
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_COUNT, 32'd0);
        bus_wr(A_STATUS, 32'd1);
        bus_wr(A_PRESCALE, 32'd3);
        bus_wr(A_COMPARE, 32'd2);
        bus_wr(A_CTRL, 32'h05);
        step(3);
        rd_chk("ps_count0", A_COUNT, 32'd0);
        step(1);
        rd_chk("ps_count1", A_COUNT, 32'd1);
        step(7);
        check("ps_int_lo", {27'd0, int_}, 32'd0);
        step(1);
        check("ps_int_hi", {27'd0, int_}, 32'h10);
        rd_chk("ps_count3", A_COUNT, 32'd3);
        bus_wr(A_COMPARE, 32'd2);
        rd_chk("ps_cmp_clr", A_STATUS, 32'd0);
        bus_wr(A_PRESCALE, 32'd0);
`endif

        // Wrap: silent rollover, no pending
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_COUNT, 32'hFFFF_FFFE);
        bus_wr(A_COMPARE, 32'h10);
        bus_wr(A_PRESCALE, 32'd0);
        bus_wr(A_CTRL, 32'h05);
        step(1);
        rd_chk("wrap_max", A_COUNT, 32'hFFFF_FFFF);
        step(1);
        rd_chk("wrap_zero", A_COUNT, 32'd0);
        rd_chk("wrap_status", A_STATUS, 32'd0);
        check("wrap_int", {27'd0, int_}, 32'd0);

        // Collision: W1C of TPEND lands on the matching tick, set wins
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_COUNT, 32'd3);
        bus_wr(A_COMPARE, 32'd5);
        bus_wr(A_CTRL, 32'h05);
        step(2);
        rd_chk("col_count5", A_COUNT, 32'd5);
        check("col_int_lo", {27'd0, int_}, 32'd0);
        bus_wr(A_STATUS, 32'd1);
        check("col_int_hi", {27'd0, int_}, 32'h10);
        rd_chk("col_status", A_STATUS, 32'd1);
        rd_chk("col_count6", A_COUNT, 32'd6);

        // External edge on line 1 (unmasked), then line 0 (masked)
        bus_wr(A_CTRL, 32'h20);
        bus_wr(A_STATUS, 32'h1F);
        rd_chk("ext_clean", A_STATUS, 32'd0);
        @(negedge clk);
        ext_irq[1] = 1'b1;
        step(1);
        rd_chk("ext_k", A_STATUS, 32'd0);
        step(1);
        rd_chk("ext_k1", A_STATUS, 32'd0);
        check("ext_k1_int", {27'd0, int_}, 32'd0);
        step(1);
        rd_chk("ext_k2", A_STATUS, 32'h04);
        check("ext_k2_int", {27'd0, int_}, 32'h02);
        bus_wr(A_STATUS, 32'h04);
        rd_chk("ext_w1c", A_STATUS, 32'd0);
        step(5);
        rd_chk("ext_level", A_STATUS, 32'd0);
        check("ext_level_int", {27'd0, int_}, 32'd0);
        @(negedge clk);
        ext_irq[0] = 1'b1;
        step(1);
        @(negedge clk);
        ext_irq[0] = 1'b0;
        step(2);
        rd_chk("ext_mask_pend", A_STATUS, 32'h02);
        check("ext_mask_int", {27'd0, int_}, 32'd0);
        @(negedge clk);
        ext_irq[1] = 1'b0;
        step(3);

        // Reset mid-count with timer and external pendings live
        bus_wr(A_COMPARE, 32'd2);
        bus_wr(A_COUNT, 32'd0);
        bus_wr(A_CTRL, 32'h37);
        step(3);
        check("mid_pre_int", {27'd0, int_}, 32'h11);
        @(negedge clk);
        rst = 1'b1;
        step(1);
        check("mid_rst_int", {27'd0, int_}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("mid_count",    A_COUNT,    32'd0);
        rd_chk("mid_compare",  A_COMPARE,  32'd0);
        rd_chk("mid_ctrl",     A_CTRL,     32'd0);
        rd_chk("mid_status",   A_STATUS,   32'd0);
        rd_chk("mid_prescale", A_PRESCALE, 32'd0);
        step(3);
        rd_chk("mid_hold", A_COUNT, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
